// File: rtl/read_page_ctrl.sv
// NAND page-read sequencer: paces byte reads against free slots of an 8-entry show-ahead FIFO.
// Define READ_PAGE_CSUM_EN to add o_csum, a 16-bit wrap-around sum of the bytes of each transfer.
module read_page_ctrl #(
    parameter int unsigned LEN_W   = 12,
    parameter int unsigned FIFO_AW = 3
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [LEN_W-1:0]   i_byte_cnt,
    input  logic               i_nf_rb_n,
    output logic               o_rd_byte_en,
    input  logic               i_rd_byte_ack,
    input  logic [7:0]         i_rd_byte_data,
    output logic [7:0]         o_dout,
    output logic               o_dout_valid,
    input  logic               i_dout_ready,
    output logic               o_busy,
    output logic               o_done,
    output logic [FIFO_AW:0]   o_fifo_level
`ifdef READ_PAGE_CSUM_EN
    ,
    output logic [15:0]        o_csum
`endif
);

    localparam int unsigned      DEPTH  = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] L_FULL = (FIFO_AW + 1)'(DEPTH);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WAIT_RB  = 3'd1;
    localparam logic [2:0] S_ISSUE    = 3'd2;
    localparam logic [2:0] S_WAIT_ACK = 3'd3;
    localparam logic [2:0] S_DRAIN    = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    logic [2:0]         r_state;
    logic [LEN_W-1:0]   r_remaining;
    logic               r_rd_byte_en;
    logic               r_busy;
    logic               r_done;
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_level;
    logic [7:0]         r_mem [DEPTH];

    logic [2:0]         w_state_nxt;
    logic [LEN_W-1:0]   w_remaining_nxt;
    logic               w_rd_en_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic               w_start_acc;
    logic               w_push;
    logic               w_pop;
    logic               w_empty;
    logic               w_full;
    logic [FIFO_AW:0]   w_level_nxt;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == L_FULL);

    // Acks are only honoured while a request is outstanding; strays elsewhere are dropped.
    assign w_push = (r_state == S_WAIT_ACK) && i_rd_byte_ack;
    assign w_pop  = !w_empty && i_dout_ready;

    always_comb begin
        w_level_nxt = r_level;
        if (w_push && !w_pop) begin
            w_level_nxt = r_level + (FIFO_AW + 1)'(1);
        end else if (!w_push && w_pop) begin
            w_level_nxt = r_level - (FIFO_AW + 1)'(1);
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_rd_en_nxt     = 1'b0;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;
        w_start_acc     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_start_acc     = 1'b1;
                    w_busy_nxt      = 1'b1;
                    w_remaining_nxt = i_byte_cnt;
                    w_state_nxt     = (i_byte_cnt == '0) ? S_DONE : S_WAIT_RB;
                end
            end
            S_WAIT_RB: begin
                if (i_nf_rb_n) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // One byte in flight at most, so a free slot now is still free at ack time.
                if (!w_full) begin
                    w_rd_en_nxt = 1'b1;
                    w_state_nxt = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (i_rd_byte_ack) begin
                    if (r_remaining != '0) begin
                        w_remaining_nxt = r_remaining - LEN_W'(1);
                    end
                    w_state_nxt = (r_remaining <= LEN_W'(1)) ? S_DRAIN : S_ISSUE;
                end
            end
            S_DRAIN: begin
                if (w_level_nxt == '0) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_remaining  <= '0;
            r_rd_byte_en <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_remaining  <= w_remaining_nxt;
            r_rd_byte_en <= w_rd_en_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_level      <= w_level_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_rd_byte_data;
        end
    end

`ifdef READ_PAGE_CSUM_EN
    logic [15:0] r_csum;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_csum <= '0;
        end else if (w_start_acc) begin
            r_csum <= '0;
        end else if (w_push) begin
            r_csum <= r_csum + {8'h00, i_rd_byte_data};
        end
    end

    assign o_csum = r_csum;
`endif

    // Head is masked when empty so dout reads 00 out of reset without clearing the array.
    assign o_dout       = w_empty ? 8'h00 : r_mem[r_rd_ptr];
    assign o_dout_valid = !w_empty;
    assign o_rd_byte_en = r_rd_byte_en;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_fifo_level = r_level;

endmodule

// File: tb/tb_read_page_ctrl.sv
// Randomised scoreboard bench for read_page_ctrl: a byte-stage responder model feeds data,
// a monitor checks every delivered byte and each done pulse against queued expectations.
module tb_read_page_ctrl;

    localparam int unsigned LEN_W   = 12;
    localparam int unsigned FIFO_AW = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [11:0] byte_cnt;
    logic        nf_rb_n;
    logic        rd_byte_en;
    logic        rd_byte_ack;
    logic [7:0]  rd_byte_data;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        busy;
    logic        done;
    logic [3:0]  fifo_level;
`ifdef READ_PAGE_CSUM_EN
    logic [15:0] csum;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [7:0] rsp_q [$];
    logic [7:0] exp_q [$];

    // Responder controls and statistics
    bit rsp_en        = 1'b1;
    int rsp_max_dly   = 0;
    bit stray_req     = 1'b0;
    bit gap_chk       = 1'b0;
    bit pending       = 1'b0;
    int wait_n        = 0;
    int en_cnt        = 0;
    int ack_cnt       = 0;
    int last_ack_edge = -10;
    int first_en_edge = -1;

    int ready_mode    = 1;  // 0 low, 1 high, 2 random
    int pop_cnt       = 0;
    int done_cnt      = 0;
    int last_done_edge = -1;
    int start_edge    = 0;

    read_page_ctrl #(
        .LEN_W   (LEN_W),
        .FIFO_AW (FIFO_AW)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (start),
        .i_byte_cnt     (byte_cnt),
        .i_nf_rb_n      (nf_rb_n),
        .o_rd_byte_en   (rd_byte_en),
        .i_rd_byte_ack  (rd_byte_ack),
        .i_rd_byte_data (rd_byte_data),
        .o_dout         (dout),
        .o_dout_valid   (dout_valid),
        .i_dout_ready   (dout_ready),
        .o_busy         (busy),
        .o_done         (done),
        .o_fifo_level   (fifo_level)
`ifdef READ_PAGE_CSUM_EN
        ,
        .o_csum         (csum)
`endif
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Byte-read stage model: acks each request after 0..rsp_max_dly cycles with the next byte.
    initial begin
        rd_byte_ack  = 1'b0;
        rd_byte_data = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            rd_byte_ack = 1'b0;
            if (!rsp_en) begin
                pending = 1'b0;
            end else if (rd_byte_en) begin
                en_cnt++;
                if (first_en_edge < 0) begin
                    first_en_edge = cyc;
                end else if (gap_chk) begin
                    check("req_after_ack", cyc, last_ack_edge + 1);
                end
                check("one_in_flight", int'(pending), 0);
                pending = 1'b1;
                wait_n  = $urandom_range(0, rsp_max_dly);
            end
            if (stray_req) begin
                rd_byte_ack  = 1'b1;
                rd_byte_data = 8'h3C;
                stray_req    = 1'b0;
            end else if (pending) begin
                if (wait_n == 0) begin
                    pending     = 1'b0;
                    rd_byte_ack = 1'b1;
                    if (rsp_q.size() > 0) begin
                        rd_byte_data = rsp_q.pop_front();
                    end else begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL extra_request: got request %0d, want none", en_cnt);
                        rd_byte_data = 8'h00;
                    end
                    ack_cnt++;
                    last_ack_edge = cyc + 1;
                end else begin
                    wait_n--;
                end
            end
        end
    end

    initial begin
        dout_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       dout_ready = 1'b0;
                1:       dout_ready = 1'b1;
                default: dout_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: compares every accepted byte and every done pulse.
    initial forever begin
        @(negedge clk);
        if (rd_byte_ack) begin
            n_tests++;
            assert (fifo_level < 4'd8) else begin
                n_fail++;
                $display("FAIL push_when_full: got level %0d, want < 8", fifo_level);
            end
        end
        if (dout_valid && dout_ready) begin
            pop_cnt++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_pop: got 0x%02h, want no data", dout);
            end else begin
                check("dout", int'(dout), int'(exp_q.pop_front()));
            end
        end
        if (done) begin
            done_cnt++;
            last_done_edge = cyc;
            check("busy_at_done", int'(busy), 0);
            check("drained_at_done", exp_q.size(), 0);
            check("level_at_done", int'(fifo_level), 0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input int n, output int sum);
        sum = 0;
        for (int i = 0; i < n; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            rsp_q.push_back(b);
            exp_q.push_back(b);
            sum = (sum + int'(b)) % 65536;
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        rsp_q.push_back(b);
        exp_q.push_back(b);
    endtask

    task automatic pulse_start(input int n);
        first_en_edge = -1;
        start    = 1'b1;
        byte_cnt = 12'(n);
        tick(1);
        start_edge = cyc;
        start      = 1'b0;
    endtask

    task automatic wait_done(input int bound, input string name);
        int d0;
        int k;
        d0 = done_cnt;
        k  = 0;
        while (done_cnt == d0 && k < bound) begin
            tick(1);
            k++;
        end
        if (done_cnt == d0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got no done in %0d cycles, want done", name, bound);
        end
    endtask

    initial begin
        int e0;
        int d0;
        int p0;
        int a0;
        int k;
        int n;
        int sum;
        int rise_edge;

        rst      = 1'b1;
        start    = 1'b0;
        byte_cnt = '0;
        nf_rb_n  = 1'b1;
        tick(2);
        rst = 1'b0;
        check("reset_busy", int'(busy), 0);
        check("reset_rd_en", int'(rd_byte_en), 0);
        check("reset_done", int'(done), 0);
        check("reset_valid", int'(dout_valid), 0);
        check("reset_level", int'(fifo_level), 0);
        check("reset_dout", int'(dout), 0);
`ifdef READ_PAGE_CSUM_EN
        check("reset_csum", int'(csum), 0);
`endif

        // Basic 4-byte transfer, immediate acks, free-flowing sink
        tick(2);
        rsp_max_dly = 0;
        gap_chk     = 1'b1;
        e0 = en_cnt;
        d0 = done_cnt;
        push_byte(8'hA5);
        push_byte(8'h5A);
        push_byte(8'h00);
        push_byte(8'hFF);
        pulse_start(4);
        wait_done(100, "basic");
        check("basic_first_req", first_en_edge - start_edge, 2);
        check("basic_req_count", en_cnt - e0, 4);
        check("basic_done_latency", last_done_edge - last_ack_edge, 2);
        check("basic_done_pulse", int'(done), 0);
        check("basic_busy_after", int'(busy), 0);
        tick(3);
        check("basic_done_once", done_cnt - d0, 1);

        // Flash busy for 20 cycles after start
        nf_rb_n = 1'b0;
        e0 = en_cnt;
        load(2, sum);
        pulse_start(2);
        tick(20);
        check("rb_no_req", en_cnt - e0, 0);
        nf_rb_n   = 1'b1;
        rise_edge = cyc + 1;
        wait_done(100, "rb");
        check("rb_first_req", first_en_edge - rise_edge, 1);
        check("rb_req_count", en_cnt - e0, 2);

        // Backpressure: sink stalled, only 8 requests fit
        gap_chk     = 1'b0;
        rsp_max_dly = 2;
        ready_mode  = 0;
        tick(2);
        e0 = en_cnt;
        d0 = done_cnt;
        p0 = pop_cnt;
        load(20, sum);
        pulse_start(20);
        tick(80);
        check("bp_req_count", en_cnt - e0, 8);
        check("bp_level", int'(fifo_level), 8);
        check("bp_valid", int'(dout_valid), 1);
        check("bp_busy", int'(busy), 1);
        check("bp_no_done", done_cnt - d0, 0);
        ready_mode = 2;
        wait_done(600, "bp");
        check("bp_req_total", en_cnt - e0, 20);
        check("bp_pop_total", pop_cnt - p0, 20);

        // Zero length: straight to done, no requests
        ready_mode = 1;
        tick(2);
        e0 = en_cnt;
        pulse_start(0);
        wait_done(10, "zero");
        check("zero_done_latency", last_done_edge - start_edge, 1);
        check("zero_no_req", en_cnt - e0, 0);

        // Start while busy is ignored
        tick(2);
        e0 = en_cnt;
        p0 = pop_cnt;
        load(3, sum);
        pulse_start(3);
        tick(1);
        start    = 1'b1;
        byte_cnt = 12'd7;
        tick(1);
        start = 1'b0;
        wait_done(200, "ignored_start");
        tick(5);
        check("ign_req_count", en_cnt - e0, 3);
        check("ign_pop_count", pop_cnt - p0, 3);

        // Randomised transfers
        for (int t = 0; t < 8; t++) begin
            n           = $urandom_range(1, 25);
            rsp_max_dly = $urandom_range(0, 3);
            ready_mode  = 2;
            nf_rb_n     = 1'b0;
            e0 = en_cnt;
            load(n, sum);
            pulse_start(n);
            tick($urandom_range(0, 5));
            nf_rb_n = 1'b1;
            wait_done(1000, "rand");
            check("rand_req_count", en_cnt - e0, n);
`ifdef READ_PAGE_CSUM_EN
            check("rand_csum", int'(csum), sum);
`endif
            tick($urandom_range(0, 3));
        end

        // Reset after 3 of 10 bytes
        ready_mode  = 0;
        rsp_max_dly = 1;
        tick(2);
        load(10, sum);
        a0 = ack_cnt;
        pulse_start(10);
        k = 0;
        while (ack_cnt - a0 < 3 && k < 200) begin
            tick(1);
            k++;
        end
        check("rst_acks_before", ack_cnt - a0, 3);
        rsp_en = 1'b0;
        rst    = 1'b1;
        tick(2);
        rst = 1'b0;
        check("rst_busy", int'(busy), 0);
        check("rst_rd_en", int'(rd_byte_en), 0);
        check("rst_level", int'(fifo_level), 0);
        check("rst_valid", int'(dout_valid), 0);
        rsp_q.delete();
        exp_q.delete();
        stray_req = 1'b1;
        tick(4);
        check("stray_level", int'(fifo_level), 0);
        check("stray_valid", int'(dout_valid), 0);
        check("stray_busy", int'(busy), 0);
        rsp_en     = 1'b1;
        ready_mode = 1;
        tick(2);
        e0 = en_cnt;
        load(5, sum);
        pulse_start(5);
        wait_done(200, "post_reset");
        check("post_reset_req_count", en_cnt - e0, 5);

`ifdef READ_PAGE_CSUM_EN
        tick(2);
        push_byte(8'hFF);
        push_byte(8'hFF);
        push_byte(8'h02);
        pulse_start(3);
        wait_done(200, "csum");
        check("csum_final", int'(csum), 16'h0200);
        tick(3);
        check("csum_stable", int'(csum), 16'h0200);
        load(1, sum);
        pulse_start(1);
        check("csum_cleared", int'(csum), 0);
        wait_done(200, "csum2");
        check("csum_single", int'(csum), sum);
`endif

        tick(5);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: got no completion by time limit, want finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
